mem_readout_tx: RTL
===================

Name: mem_readout_tx

Overview:
- Read-side master for the photon-count data memory.
- On a start pulse it issues a programmed number of RD strobes to the memory, waits for the memory to present each stored 16-bit word, captures it, and serialises it over a UART 8N1 line to the host PC.
- Sits between the count memory and the host serial link. It is the readout counterpart to the DMD-driven write path.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- RD_HIGH_CYCLES, 4, cycles rd is held high per strobe. Must be ≥ 3 so the memory's 3-stage synchroniser sees it.
- RD_SETTLE_CYCLES, 8, cycles after rd falls before mem_data is sampled. Must be ≥ 5.
- HEADER_BYTE, 8'hA5, byte sent once before the payload of each readout.
- MAX_WORDS, 1024, upper clamp on word_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a readout; ignored while busy=1.
- word_count  in  11  number of words to read. Sampled on the accepted start.
- mem_data  in  16  data_out of the count memory.
- rd  out  1  read strobe to the memory's RD input.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final stop bit completes.
- words_sent  out  11  number of words fully transmitted in the current or last readout.

Behaviour:
- Reset values: rd=0, tx=1, busy=0, done=0, words_sent=0, FSM=IDLE.
- Reset mid-operation aborts immediately, including mid-byte on tx. No done pulse is generated.
- FSM states:
  - IDLE: on start, latch n = min(word_count, MAX_WORDS), clear words_sent, set busy, load HEADER_BYTE into the TX shifter, go to SEND.
  - SEND: byte serialiser. Start bit (0), then 8 data bits LSB first, then stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, so a byte takes 10*CLKS_PER_BIT cycles. On stop-bit end, the return state depends on which byte was sent:
    - header → if n==0 go to FIN, else go to RD_HI.
    - high byte → load low byte, stay in SEND.
    - low byte → words_sent++, then if words_sent==n go to FIN, else go to RD_HI.
  - RD_HI: rd=1 for RD_HIGH_CYCLES cycles, then go to RD_WAIT with rd=0.
  - RD_WAIT: count RD_SETTLE_CYCLES cycles, then register mem_data into a 16-bit capture register and go to SEND with the high byte [15:8] loaded.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Exactly one rd strobe per word. rd is never high outside RD_HI.
- tx is held at 1 in every state except SEND.
- Consecutive bytes are sent back-to-back: there are 0 idle cycles between one stop bit and the next start bit, both within a word and from header to high byte.
- Idle time between words is RD_HIGH_CYCLES + RD_SETTLE_CYCLES cycles, with tx=1 throughout.
- Wire order per readout: HEADER_BYTE, then for each word k: hi(k), lo(k).
- word_count > MAX_WORDS is clamped to MAX_WORDS. word_count = 0 sends the header only, then pulses done.
- start asserted in the same cycle as FIN is ignored. A new readout is accepted starting the cycle after done.
- words_sent holds its final value after done until the next accepted start.
- All counters are sized to their maximum value; none of them wrap.

Test Plan:
- Reset/idle (CLKS_PER_BIT=4): hold rst 5 cycles → rd=0, tx=1, busy=0, done=0, words_sent=0. start pulse during rst → no activity.
- Single word: memory model returns 16'h1234 after rd falls; start, word_count=1 → tx bytes A5, 12, 34 decoded. Exactly 1 rd pulse 4 cycles wide. done one cycle after the final stop bit. words_sent=1.
- Multi-word order: model words 16'h0001, 16'h00FF, 16'hBEEF, word_count=3 → bytes A5 00 01 00 FF BE EF. 3 rd pulses, each separated from the prior low-byte stop by 0 cycles. Inter-word tx-high gap is 12 cycles.
- Boundaries: word_count=0 → only A5 sent, done, 0 rd pulses. word_count=1500 → 1024 rd pulses, words_sent=1024.
- start while busy: pulse start mid-readout with a different word_count → ignored; transfer completes with the original n, single done.
- Reset mid-byte: assert rst during the 4th data bit → tx=1 and busy=0 the next cycle, no done. A following start, word_count=1 → a clean A5 header.

Source files
------------

// File: rtl/mem_readout_tx.sv
// Readout master for the photon-count memory: strobes RD once per word, captures
// the settled 16-bit word and streams header + hi/lo bytes over a UART 8N1 line.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; tx idles high
// SEND    | shifting one byte: start bit, 8 data bits LSB first, stop bit
// RD_HI   | rd held high for RD_HIGH_CYCLES
// RD_WAIT | rd low, waiting RD_SETTLE_CYCLES before sampling mem_data
// FIN     | one-cycle done pulse, then back to IDLE
module mem_readout_tx #(
    parameter int         CLKS_PER_BIT     = 434,
    parameter int         RD_HIGH_CYCLES   = 4,
    parameter int         RD_SETTLE_CYCLES = 8,
    parameter logic [7:0] HEADER_BYTE      = 8'hA5,
    parameter int         MAX_WORDS        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic [15:0] mem_data,
    output logic        rd,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [10:0] words_sent
);

    localparam int TMR_MAX_A = (CLKS_PER_BIT > RD_HIGH_CYCLES) ? CLKS_PER_BIT : RD_HIGH_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > RD_SETTLE_CYCLES) ? TMR_MAX_A : RD_SETTLE_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] BIT_LD    = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] RD_HI_LD  = TMR_W'(RD_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(RD_SETTLE_CYCLES - 1);
    localparam logic [10:0]      MAX_N     = 11'(MAX_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_RD_HI, S_RD_WAIT, S_FIN} state_t;
    typedef enum logic [1:0] {B_HDR, B_HI, B_LO} byte_t;

    state_t           state, state_nxt;
    byte_t            byte_sel;
    logic [10:0]      n_words;
    logic [TMR_W-1:0] tmr_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       tx_shift;
    logic [7:0]       mem_lo;

    logic tmr_zero, byte_end, last_word;

    assign tmr_zero  = (tmr_cnt == '0);
    assign byte_end  = (state == S_SEND) && tmr_zero && (bit_idx == 4'd9);
    assign last_word = ((words_sent + 11'd1) == n_words);

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        tx        = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SEND;
            end
            S_SEND: begin
                busy = 1'b1;
                if (bit_idx == 4'd0)      tx = 1'b0;
                else if (bit_idx == 4'd9) tx = 1'b1;
                else                      tx = tx_shift[0];
                if (byte_end) begin
                    case (byte_sel)
                        B_HDR:   state_nxt = (n_words == '0) ? S_FIN : S_RD_HI;
                        B_HI:    state_nxt = S_SEND;
                        default: state_nxt = last_word ? S_FIN : S_RD_HI;
                    endcase
                end
            end
            S_RD_HI: begin
                busy = 1'b1;
                rd   = 1'b1;
                if (tmr_zero) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy = 1'b1;
                if (tmr_zero) state_nxt = S_SEND;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_sel   <= B_HDR;
            n_words    <= '0;
            words_sent <= '0;
            tmr_cnt    <= '0;
            bit_idx    <= '0;
            tx_shift   <= '0;
            mem_lo     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_words    <= (word_count > MAX_N) ? MAX_N : word_count;
                        words_sent <= '0;
                        tx_shift   <= HEADER_BYTE;
                        byte_sel   <= B_HDR;
                        bit_idx    <= '0;
                        tmr_cnt    <= BIT_LD;
                    end
                end
                S_SEND: begin
                    if (!tmr_zero) begin
                        tmr_cnt <= tmr_cnt - 1'b1;
                    end else if (bit_idx != 4'd9) begin
                        // data bits shift out LSB first; start bit leaves the shifter intact
                        if (bit_idx != 4'd0) tx_shift <= tx_shift >> 1;
                        bit_idx <= bit_idx + 4'd1;
                        tmr_cnt <= BIT_LD;
                    end else begin
                        case (byte_sel)
                            B_HI: begin
                                tx_shift <= mem_lo;
                                byte_sel <= B_LO;
                                bit_idx  <= '0;
                                tmr_cnt  <= BIT_LD;
                            end
                            B_LO: begin
                                words_sent <= words_sent + 11'd1;
                                tmr_cnt    <= RD_HI_LD;
                            end
                            default: tmr_cnt <= RD_HI_LD;
                        endcase
                    end
                end
                S_RD_HI: begin
                    tmr_cnt <= tmr_zero ? SETTLE_LD : tmr_cnt - 1'b1;
                end
                S_RD_WAIT: begin
                    if (tmr_zero) begin
                        tx_shift <= mem_data[15:8];
                        mem_lo   <= mem_data[7:0];
                        byte_sel <= B_HI;
                        bit_idx  <= '0;
                        tmr_cnt  <= BIT_LD;
                    end else begin
                        tmr_cnt <= tmr_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
